xpb_lut_ram: RTL and testbench

Runtime-loadable, multi-channel replacement for the fixed per-segment xpb ROMs used in the modular squaring reduction path. Holds 2^IDX_BITS precomputed reduction constants (entry k = k*2^offset mod N), written by the host load path after reset or modulus change. Serves NUM_CHAN independent registered lookups per cycle. Tracks fill state so the squaring loop can be held off until the table is complete.

---
 rtl/xpb_lut_pkg.sv | 17 +
 rtl/xpb_lut_port.sv | 62 ++++++
 rtl/xpb_lut_ram.sv | 129 ++++++++++++
 tb/tb_xpb_lut_ram.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/xpb_lut_pkg.sv
// xpb_lut_pkg
// Shared definitions for the runtime-loadable xpb reduction-constant table.
// Holds the fill-state enum and the default entry/index widths. The squaring
// datapath uses the same width constants.
package xpb_lut_pkg;

   localparam int XPB_DATA_WIDTH = 1024;
   localparam int XPB_IDX_BITS   = 5;

   // Fill state of the table. The squaring loop waits until READY.
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_READY   = 2'd2
   } lut_state_t;

endpackage

// File: rtl/xpb_lut_port.sv
// xpb_lut_port
// Single-channel registered lookup into the xpb constant table.
// Ports:
//   clk, reset     - clock and asynchronous active-high reset
//   rd_valid       - lookup request for this channel
//   rd_idx         - entry index to look up
//   entries        - table storage, shared with the other channels
//   loaded         - per-entry loaded flags
//   rd_data_valid  - response valid, one cycle after the request
//   rd_data        - entry value (zero for index 0 or an unloaded entry)
//   rd_miss        - response index had not been loaded
module xpb_lut_port
   import xpb_lut_pkg::*;
#(
   parameter int DATA_WIDTH = XPB_DATA_WIDTH,
   parameter int IDX_BITS   = XPB_IDX_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_valid,
   input  logic [IDX_BITS-1:0]   rd_idx,
   input  logic [DATA_WIDTH-1:0] entries [2**IDX_BITS],
   input  logic [2**IDX_BITS-1:0] loaded,
   output logic                  rd_data_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_miss
);

   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_miss;

   // Index 0 is the constant zero and is never stored, so it is never a miss.
   // An unloaded entry reads as zero so stale storage cannot leak through.
   always_comb begin
      sel_data = '0;
      sel_miss = 1'b0;
      if (rd_idx != '0) begin
         if (loaded[rd_idx]) begin
            sel_data = entries[rd_idx];
         end else begin
            sel_miss = 1'b1;
         end
      end
   end

   // The output register samples the storage before any same-edge write lands,
   // which gives read-before-write behaviour. Data and miss hold when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_valid <= 1'b0;
         rd_data       <= '0;
         rd_miss       <= 1'b0;
      end else begin
         rd_data_valid <= rd_valid;
         if (rd_valid) begin
            rd_data <= sel_data;
            rd_miss <= sel_miss;
         end
      end
   end

endmodule

// File: rtl/xpb_lut_ram.sv
// xpb_lut_ram
// Runtime-loadable multi-channel table of xpb reduction constants
// (entry k = k*2^offset mod N). The host writes it after reset or a modulus change.
// Ports:
//   clk, reset     - clock and asynchronous active-high reset
//   ld_valid       - write strobe for one entry
//   ld_idx         - entry index to write (writes to index 0 are ignored)
//   ld_data        - entry value
//   tbl_clr        - invalidate all entries (modulus change)
//   tbl_ready      - every non-zero index is loaded
//   fill_count     - number of distinct non-zero entries loaded
//   rd_valid       - per-channel lookup request
//   rd_idx         - per-channel index, channel c at [c*IDX_BITS +: IDX_BITS]
//   rd_data_valid  - per-channel response valid
//   rd_data        - per-channel value, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   rd_miss        - per-channel "index not loaded" flag
module xpb_lut_ram
   import xpb_lut_pkg::*;
#(
   parameter int DATA_WIDTH = XPB_DATA_WIDTH,
   parameter int IDX_BITS   = XPB_IDX_BITS,
   parameter int NUM_CHAN   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ld_valid,
   input  logic [IDX_BITS-1:0]            ld_idx,
   input  logic [DATA_WIDTH-1:0]          ld_data,
   input  logic                           tbl_clr,
   output logic                           tbl_ready,
   output logic [IDX_BITS-1:0]            fill_count,
   input  logic [NUM_CHAN-1:0]            rd_valid,
   input  logic [NUM_CHAN*IDX_BITS-1:0]   rd_idx,
   output logic [NUM_CHAN-1:0]            rd_data_valid,
   output logic [NUM_CHAN*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_CHAN-1:0]            rd_miss
);

   localparam int DEPTH = 2**IDX_BITS;
   localparam logic [IDX_BITS-1:0] FULL_COUNT = {IDX_BITS{1'b1}};

   logic [DATA_WIDTH-1:0] entries [DEPTH];
   logic [DEPTH-1:0]      loaded;
   lut_state_t            state;

   logic                  load_accept;
   logic                  new_entry;
   logic [IDX_BITS-1:0]   fill_next;

   // A clear in the same cycle discards the load. Index 0 is never stored.
   // Only the first write to an index since the last clear adds to the count.
   always_comb begin
      load_accept = ld_valid && !tbl_clr && (ld_idx != '0);
      new_entry   = load_accept && !loaded[ld_idx];
      fill_next   = fill_count + {{(IDX_BITS-1){1'b0}}, new_entry};
   end

   // The storage has no reset. The loaded bitmap alone decides what is valid.
   always_ff @(posedge clk) begin
      if (load_accept) begin
         entries[ld_idx] <= ld_data;
      end
   end

   // Fill tracking and FSM. tbl_ready is registered and rises on the edge
   // that writes the last missing entry. Loads in READY patch constants.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_EMPTY;
         loaded     <= '0;
         fill_count <= '0;
         tbl_ready  <= 1'b0;
      end else if (tbl_clr) begin
         state      <= ST_EMPTY;
         loaded     <= '0;
         fill_count <= '0;
         tbl_ready  <= 1'b0;
      end else begin
         if (load_accept) begin
            loaded[ld_idx] <= 1'b1;
         end
         fill_count <= fill_next;
         case (state)
            ST_EMPTY: begin
               if (load_accept) begin
                  if (fill_next == FULL_COUNT) begin
                     state     <= ST_READY;
                     tbl_ready <= 1'b1;
                  end else begin
                     state <= ST_FILLING;
                  end
               end
            end
            ST_FILLING: begin
               if (fill_next == FULL_COUNT) begin
                  state     <= ST_READY;
                  tbl_ready <= 1'b1;
               end
            end
            ST_READY: begin
               tbl_ready <= 1'b1;
            end
            default: begin
               state     <= ST_EMPTY;
               tbl_ready <= 1'b0;
            end
         endcase
      end
   end

   // One independent registered lookup port per channel.
   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      xpb_lut_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .IDX_BITS   (IDX_BITS)
      ) u_port (
         .clk           (clk),
         .reset         (reset),
         .rd_valid      (rd_valid[c]),
         .rd_idx        (rd_idx[c*IDX_BITS +: IDX_BITS]),
         .entries       (entries),
         .loaded        (loaded),
         .rd_data_valid (rd_data_valid[c]),
         .rd_data       (rd_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .rd_miss       (rd_miss[c])
      );
   end

endmodule

// File: tb/tb_xpb_lut_ram.sv
// tb_xpb_lut_ram
// Directed self-checking bench for xpb_lut_ram with the default parameters.
module tb_xpb_lut_ram;

   localparam int DW = 1024;
   localparam int IB = 5;
   localparam int NC = 4;

   logic               clk;
   logic               reset;
   logic               ld_valid;
   logic [IB-1:0]      ld_idx;
   logic [DW-1:0]      ld_data;
   logic               tbl_clr;
   logic               tbl_ready;
   logic [IB-1:0]      fill_count;
   logic [NC-1:0]      rd_valid;
   logic [NC*IB-1:0]   rd_idx;
   logic [NC-1:0]      rd_data_valid;
   logic [NC*DW-1:0]   rd_data;
   logic [NC-1:0]      rd_miss;

   int pass_count = 0;
   int check_count = 0;

   xpb_lut_ram #(
      .DATA_WIDTH (DW),
      .IDX_BITS   (IB),
      .NUM_CHAN   (NC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ld_valid      (ld_valid),
      .ld_idx        (ld_idx),
      .ld_data       (ld_data),
      .tbl_clr       (tbl_clr),
      .tbl_ready     (tbl_ready),
      .fill_count    (fill_count),
      .rd_valid      (rd_valid),
      .rd_idx        (rd_idx),
      .rd_data_valid (rd_data_valid),
      .rd_data       (rd_data),
      .rd_miss       (rd_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected table contents used by the load sequence.
   function automatic logic [DW-1:0] entryVal(input int k);
      logic [31:0] v;
      v = k * 32'h1111;
      return DW'(v);
   endfunction

   function automatic logic [NC*IB-1:0] packIdx(input int i0, input int i1, input int i2, input int i3);
      logic [IB-1:0] a, b, c, d;
      a = IB'(i0);
      b = IB'(i1);
      c = IB'(i2);
      d = IB'(i3);
      return {d, c, b, a};
   endfunction

   // Drive one cycle of inputs, then step to just after the next rising edge.
   task automatic applyStimulus(input logic ldv, input int li, input logic [DW-1:0] ld,
                                input logic clr, input logic [NC-1:0] rv,
                                input logic [NC*IB-1:0] ri);
      ld_valid = ldv;
      ld_idx   = IB'(li);
      ld_data  = ld;
      tbl_clr  = clr;
      rd_valid = rv;
      rd_idx   = ri;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      check_count++;
      assert (observed === expected) pass_count++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed[127:0], expected[127:0]);
   endtask

   initial begin
      reset    = 1'b1;
      ld_valid = 1'b0;
      ld_idx   = '0;
      ld_data  = '0;
      tbl_clr  = 1'b0;
      rd_valid = '0;
      rd_idx   = '0;

      // Reset state
      #12;
      checkOutput("reset_fill_count", DW'(fill_count), '0);
      checkOutput("reset_tbl_ready", DW'(tbl_ready), '0);
      checkOutput("reset_rd_data_valid", DW'(rd_data_valid), '0);
      checkOutput("reset_rd_miss", DW'(rd_miss), '0);
      checkOutput("reset_rd_data_ch0", rd_data[0 +: DW], '0);
      #10;
      reset = 1'b0;

      // Reads of an empty table miss on every channel
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b1111, packIdx(3, 3, 3, 3));
      checkOutput("empty_rd_data_valid", DW'(rd_data_valid), DW'(4'b1111));
      checkOutput("empty_rd_miss", DW'(rd_miss), DW'(4'b1111));
      checkOutput("empty_rd_data_ch1", rd_data[DW +: DW], '0);
      checkOutput("empty_rd_data_ch3", rd_data[3*DW +: DW], '0);
      checkOutput("empty_tbl_ready", DW'(tbl_ready), '0);

      // Fill indices 1..31. Ready rises on the edge that writes index 31.
      for (int k = 1; k < 32; k++) begin
         applyStimulus(1'b1, k, entryVal(k), 1'b0, '0, '0);
         checkOutput($sformatf("fill_count_k%0d", k), DW'(fill_count), DW'(k));
         checkOutput($sformatf("tbl_ready_k%0d", k), DW'(tbl_ready), DW'(k == 31));
      end

      // Four-channel lookup of a full table
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b1111, packIdx(0, 1, 17, 31));
      checkOutput("full_rd_data_valid", DW'(rd_data_valid), DW'(4'b1111));
      checkOutput("full_rd_miss", DW'(rd_miss), '0);
      checkOutput("full_ch0_idx0", rd_data[0 +: DW], '0);
      checkOutput("full_ch1_idx1", rd_data[DW +: DW], DW'(32'h1111));
      checkOutput("full_ch2_idx17", rd_data[2*DW +: DW], DW'(32'h12221));
      checkOutput("full_ch3_idx31", rd_data[3*DW +: DW], DW'(32'h2110F));

      // Clear with a load and a read on the same edge
      applyStimulus(1'b1, 4, DW'(32'hDEAD), 1'b1, 4'b0001, packIdx(4, 0, 0, 0));
      checkOutput("clr_read_preclear_data", rd_data[0 +: DW], DW'(32'h4444));
      checkOutput("clr_read_preclear_miss", DW'(rd_miss[0]), '0);
      checkOutput("clr_fill_count", DW'(fill_count), '0);
      checkOutput("clr_tbl_ready", DW'(tbl_ready), '0);
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0001, packIdx(4, 0, 0, 0));
      checkOutput("clr_idx4_miss", DW'(rd_miss[0]), DW'(1'b1));
      checkOutput("clr_idx4_data", rd_data[0 +: DW], '0);

      // Rewrite of one index counts once and keeps the newest data
      applyStimulus(1'b1, 5, DW'(32'hAA), 1'b0, '0, '0);
      checkOutput("idx5_first_fill", DW'(fill_count), DW'(1));
      applyStimulus(1'b1, 5, DW'(32'hBB), 1'b0, '0, '0);
      checkOutput("idx5_second_fill", DW'(fill_count), DW'(1));
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0001, packIdx(5, 0, 0, 0));
      checkOutput("idx5_read", rd_data[0 +: DW], DW'(32'hBB));

      // Idle channel holds its last data with valid low
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0000, '0);
      checkOutput("idle_valid", DW'(rd_data_valid), '0);
      checkOutput("idle_hold_ch0", rd_data[0 +: DW], DW'(32'hBB));

      // Loads to index 0 are ignored
      applyStimulus(1'b1, 0, DW'(32'hFF), 1'b0, '0, '0);
      checkOutput("idx0_load_fill", DW'(fill_count), DW'(1));
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0001, packIdx(0, 0, 0, 0));
      checkOutput("idx0_read_data", rd_data[0 +: DW], '0);
      checkOutput("idx0_read_miss", DW'(rd_miss[0]), '0);

      // Read-before-write on a loaded index
      applyStimulus(1'b1, 7, DW'(32'h70), 1'b0, '0, '0);
      checkOutput("idx7_fill", DW'(fill_count), DW'(2));
      applyStimulus(1'b1, 7, DW'(32'h77), 1'b0, 4'b0100, packIdx(0, 0, 7, 0));
      checkOutput("rbw_ch2_old_data", rd_data[2*DW +: DW], DW'(32'h70));
      checkOutput("rbw_ch2_miss", DW'(rd_miss[2]), '0);
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0100, packIdx(0, 0, 7, 0));
      checkOutput("rbw_ch2_new_data", rd_data[2*DW +: DW], DW'(32'h77));

      // Read-before-write on an unloaded index
      applyStimulus(1'b1, 9, DW'(32'h99), 1'b0, 4'b0010, packIdx(0, 9, 0, 0));
      checkOutput("rbw_idx9_miss", DW'(rd_miss[1]), DW'(1'b1));
      checkOutput("rbw_idx9_data", rd_data[DW +: DW], '0);
      checkOutput("idx9_fill", DW'(fill_count), DW'(3));
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b0010, packIdx(0, 9, 0, 0));
      checkOutput("idx9_after_miss", DW'(rd_miss[1]), '0);
      checkOutput("idx9_after_data", rd_data[DW +: DW], DW'(32'h99));

      // Reset mid-fill with reads in flight
      applyStimulus(1'b0, 0, '0, 1'b1, '0, '0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b1, k, entryVal(k), 1'b0, '0, '0);
      end
      checkOutput("midfill_count", DW'(fill_count), DW'(10));
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b1111, packIdx(1, 2, 3, 4));
      checkOutput("midfill_read_ch3", rd_data[3*DW +: DW], entryVal(4));
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_valid", DW'(rd_data_valid), '0);
      checkOutput("async_rst_data_ch0", rd_data[0 +: DW], '0);
      checkOutput("async_rst_data_ch3", rd_data[3*DW +: DW], '0);
      checkOutput("async_rst_fill", DW'(fill_count), '0);
      checkOutput("async_rst_ready", DW'(tbl_ready), '0);
      rd_valid = '0;
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b1111, packIdx(1, 2, 3, 4));
      checkOutput("post_rst_miss_1to4", DW'(rd_miss), DW'(4'b1111));
      checkOutput("post_rst_valid", DW'(rd_data_valid), DW'(4'b1111));
      applyStimulus(1'b0, 0, '0, 1'b0, 4'b1111, packIdx(7, 8, 9, 10));
      checkOutput("post_rst_miss_7to10", DW'(rd_miss), DW'(4'b1111));
      checkOutput("post_rst_data_ch2", rd_data[2*DW +: DW], '0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
